// File: rtl/t06_snake_body_engine.sv
// t06_snake_body_engine: snake body shift register with growth, scoring, self/wall collision (optional macro T06_WALL_WRAP_EN wraps the grid instead of hitting walls)
module t06_snake_body_engine #(
    parameter int COORD_W    = 4,
    parameter int MAX_LENGTH = 30,
    parameter int INIT_X     = 4,
    parameter int INIT_Y     = 4
) (
    input  logic                          main_clk,
    input  logic                          nrst,
    input  logic                          enable,
    input  logic                          step,
    input  logic [1:0]                    dir,
    input  logic                          grow,
    input  logic                          restart,
    output logic [COORD_W-1:0]            head_x,
    output logic [COORD_W-1:0]            head_y,
    output logic [MAX_LENGTH*COORD_W-1:0] body_x,
    output logic [MAX_LENGTH*COORD_W-1:0] body_y,
    output logic [MAX_LENGTH-1:0]         body_valid,
    output logic [7:0]                    length,
    output logic [7:0]                    score,
    output logic                          self_hit,
    output logic                          wall_hit
);
    localparam logic [COORD_W-1:0] IX  = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] IX1 = COORD_W'(INIT_X - 1);
    localparam logic [COORD_W-1:0] IY  = COORD_W'(INIT_Y);

    function automatic logic [COORD_W-1:0] init_x(input int i);
        return (i == 0) ? IX : (i == 1) ? IX1 : '0;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int i);
        return (i < 2) ? IY : '0;
    endfunction

    logic [COORD_W-1:0] seg_x [MAX_LENGTH];
    logic [COORD_W-1:0] seg_y [MAX_LENGTH];
    logic [COORD_W-1:0] nxt_x [MAX_LENGTH];
    logic [COORD_W-1:0] nxt_y [MAX_LENGTH];
    logic [1:0]         last_dir, eff_dir, nxt_dir;
    logic [COORD_W-1:0] nx, ny;
    logic [7:0]         chk_len, new_len, new_score, nxt_len, nxt_score;
    logic               wall_mv, self_mv, load_init, nxt_self, nxt_wall;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    genvar g;
    generate
        for (g = 0; g < MAX_LENGTH; g++) begin : g_out
            assign body_x[g*COORD_W +: COORD_W] = seg_x[g];
            assign body_y[g*COORD_W +: COORD_W] = seg_y[g];
            assign body_valid[g] = 8'(g) < length;
        end
    endgenerate

    // A reversal request is dropped in favour of the previous heading
    assign eff_dir = (dir == (last_dir ^ 2'b01)) ? last_dir : dir;
    assign nx = eff_dir[1] ? (eff_dir[0] ? seg_x[0] + 1'b1 : seg_x[0] - 1'b1) : seg_x[0];
    assign ny = eff_dir[1] ? seg_y[0] : (eff_dir[0] ? seg_y[0] + 1'b1 : seg_y[0] - 1'b1);

`ifdef T06_WALL_WRAP_EN
    assign wall_mv = 1'b0;
`else
    assign wall_mv = (eff_dir == 2'b00 && seg_y[0] == '0) || (eff_dir == 2'b01 && seg_y[0] == '1) ||
                     (eff_dir == 2'b10 && seg_x[0] == '0) || (eff_dir == 2'b11 && seg_x[0] == '1);
`endif

    assign chk_len   = grow ? length : length - 8'd1;
    assign new_len   = (grow && length != 8'(MAX_LENGTH)) ? length + 8'd1 : length;
    assign new_score = (grow && score != 8'hff) ? score + 8'd1 : score;
    assign load_init = restart | (step & (wall_mv | self_mv));

    // Self collision: new head against the segments that will still be occupied
    always_comb begin
        self_mv = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++)
            self_mv = self_mv | (8'(i) < chk_len && seg_x[i] == nx && seg_y[i] == ny);
    end

    // Next body/length/score: restart or a hit reloads the start pose, a clean move shifts the body
    always_comb begin
        nxt_x[0] = load_init ? IX : step ? nx : seg_x[0];
        nxt_y[0] = load_init ? IY : step ? ny : seg_y[0];
        for (int i = 1; i < MAX_LENGTH; i++) begin
            nxt_x[i] = load_init ? init_x(i) : !step ? seg_x[i] : (8'(i) < new_len ? seg_x[i-1] : '0);
            nxt_y[i] = load_init ? init_y(i) : !step ? seg_y[i] : (8'(i) < new_len ? seg_y[i-1] : '0);
        end
        nxt_len   = load_init ? 8'd2 : step ? new_len : length;
        nxt_score = restart ? 8'd0 : (step && !wall_mv && !self_mv) ? new_score : score;
        nxt_dir   = load_init ? 2'b11 : step ? eff_dir : last_dir;
        nxt_self  = !restart && step && !wall_mv && self_mv;
        nxt_wall  = !restart && step && wall_mv;
    end

    // State register: everything frozen while disabled unless a restart arrives
    always_ff @(posedge main_clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            length   <= 8'd2;
            score    <= 8'd0;
            last_dir <= 2'b11;
            self_hit <= 1'b0;
            wall_hit <= 1'b0;
        end else if (enable || restart) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x[i] <= nxt_x[i];
                seg_y[i] <= nxt_y[i];
            end
            length   <= nxt_len;
            score    <= nxt_score;
            last_dir <= nxt_dir;
            self_hit <= nxt_self;
            wall_hit <= nxt_wall;
        end
    end
endmodule
